// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants for the register file and ALU sub-blocks.
package rv32i_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREG       = 32;

  typedef logic [REG_ADDR_W-1:0] regaddr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam regaddr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_rv32i.sv
// Pending-write scoreboard: one bit per register, popcount counter and operand hazard flag.
module reg_scoreboard_rv32i
  import rv32i_pkg::*;
#(
  parameter int unsigned NREG      = rv32i_pkg::NREG,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_rd_we,
  input  logic [4:0] i_rd_addr,
  input  logic       i_pend_set,
  input  logic [4:0] i_pend_addr,
  output logic       o_hazard,
  output logic [5:0] o_pend_count
);

  localparam logic [5:0] CountMax = 6'(NREG - 1);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_next;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_clr_vec;
  logic [5:0]      r_pend_count;
  logic [5:0]      w_count_next;
  logic            w_set_eff;
  logic            w_clr_eff;
  logic            w_fwd1;
  logic            w_fwd2;

  // Next pending mask and count; a set on the same register as a completing write wins.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (i_pend_set && (i_pend_addr != REG_ZERO)) w_set_vec[i_pend_addr] = 1'b1;
    if (i_rd_we && (i_rd_addr != REG_ZERO))      w_clr_vec[i_rd_addr]   = 1'b1;
    w_pend_next  = (r_pend & ~w_clr_vec) | w_set_vec;
    w_set_eff    = |(w_set_vec & ~r_pend);
    w_clr_eff    = |(w_clr_vec & r_pend & ~w_set_vec);
    w_count_next = r_pend_count;
    if (w_set_eff && !w_clr_eff && (r_pend_count != CountMax)) begin
      w_count_next = r_pend_count + 6'd1;
    end else if (!w_set_eff && w_clr_eff && (r_pend_count != 6'd0)) begin
      w_count_next = r_pend_count - 6'd1;
    end
  end

  // Scoreboard state; pending marks are dropped on reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= '0;
      r_pend_count <= 6'd0;
    end else begin
      r_pend       <= w_pend_next;
      r_pend_count <= w_count_next;
    end
  end

  // A write completing this cycle satisfies the hazard only when it is forwarded.
  always_comb begin
    w_fwd1   = (BYPASS_EN != 0) && i_rd_we && (i_rd_addr == i_rs1_addr);
    w_fwd2   = (BYPASS_EN != 0) && i_rd_we && (i_rd_addr == i_rs2_addr);
    o_hazard = ((i_rs1_addr != REG_ZERO) && r_pend[i_rs1_addr] && !w_fwd1) ||
               ((i_rs2_addr != REG_ZERO) && r_pend[i_rs2_addr] && !w_fwd2);
  end

  assign o_pend_count = r_pend_count;

endmodule

// File: rtl/reg_file_rv32i.sv
// RV32I integer register file: 2 async read ports, 1 sync write port, bypass and scoreboard.
module reg_file_rv32i
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN      = rv32i_pkg::XLEN,
  parameter int unsigned NREG      = rv32i_pkg::NREG,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rd_we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            pend_set,
  input  logic [4:0]      pend_addr,
  output logic            hazard,
  output logic [5:0]      pend_count
);

  logic [XLEN-1:0] r_regs [NREG];

  // Register array write; x0 is never written so it stays 0.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (rd_we && (rd_addr != REG_ZERO)) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  // Combinational read ports with optional same-cycle forwarding of the write data.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != REG_ZERO) begin
      if ((BYPASS_EN != 0) && rd_we && (rd_addr == rs1_addr)) rs1_data = rd_data;
      else                                                    rs1_data = r_regs[rs1_addr];
    end
    if (rs2_addr != REG_ZERO) begin
      if ((BYPASS_EN != 0) && rd_we && (rd_addr == rs2_addr)) rs2_data = rd_data;
      else                                                    rs2_data = r_regs[rs2_addr];
    end
  end

  reg_scoreboard_rv32i #(
    .NREG      (NREG),
    .BYPASS_EN (BYPASS_EN)
  ) u_scoreboard (
    .clock        (clock),
    .rst_n        (rst_n),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .i_rd_we      (rd_we),
    .i_rd_addr    (rd_addr),
    .i_pend_set   (pend_set),
    .i_pend_addr  (pend_addr),
    .o_hazard     (hazard),
    .o_pend_count (pend_count)
  );

endmodule

// File: tb/tb_reg_file_rv32i.sv
// Bench for reg_file_rv32i: table vectors, corner sequences and random traffic vs a model.
module tb_reg_file_rv32i;

  logic        clock;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, pend_addr;
  logic        rd_we, pend_set;
  logic [31:0] rd_data;
  logic [31:0] b_rs1, b_rs2, n_rs1, n_rs2;
  logic        b_haz, n_haz;
  logic [5:0]  b_cnt, n_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural registers and pending set.
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  reg_file_rv32i #(.XLEN(32), .NREG(32), .BYPASS_EN(1)) u_dut_byp (
    .clock(clock), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1), .rs2_data(b_rs2), .rd_we(rd_we), .rd_addr(rd_addr),
    .rd_data(rd_data), .pend_set(pend_set), .pend_addr(pend_addr),
    .hazard(b_haz), .pend_count(b_cnt)
  );

  reg_file_rv32i #(.XLEN(32), .NREG(32), .BYPASS_EN(0)) u_dut_nobyp (
    .clock(clock), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1), .rs2_data(n_rs2), .rd_we(rd_we), .rd_addr(rd_addr),
    .rd_data(rd_data), .pend_set(pend_set), .pend_addr(pend_addr),
    .hazard(n_haz), .pend_count(n_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ps;
    logic [4:0]  pa;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eh;
    logic [5:0]  ec;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic ps, input logic [4:0] pa);
    rd_we = we; rd_addr = wa; rd_data = wd;
    rs1_addr = r1; rs2_addr = r2; pend_set = ps; pend_addr = pa;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && rd_we && rd_addr == a) return rd_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_haz(input bit byp);
    bit h1, h2;
    h1 = (rs1_addr != 0) && m_pend[rs1_addr] && !(byp && rd_we && rd_addr == rs1_addr);
    h2 = (rs2_addr != 0) && m_pend[rs2_addr] && !(byp && rd_we && rd_addr == rs2_addr);
    return h1 || h2;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Completing write releases the register first; a new load in the same cycle re-marks it.
  task automatic model_update();
    if (rd_we && rd_addr != 0) begin
      m_regs[rd_addr] = rd_data;
      m_pend[rd_addr] = 1'b0;
    end
    if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
  endtask

  task automatic check_model(input string tag, input int idx, input bit do_byp);
    if (do_byp) begin
      chk({tag, "_b_rs1"}, idx, b_rs1, exp_rd(rs1_addr, 1'b1));
      chk({tag, "_b_rs2"}, idx, b_rs2, exp_rd(rs2_addr, 1'b1));
      chk({tag, "_b_haz"}, idx, {31'd0, b_haz}, {31'd0, exp_haz(1'b1)});
      chk({tag, "_b_cnt"}, idx, {26'd0, b_cnt}, exp_cnt());
    end
    chk({tag, "_n_rs1"}, idx, n_rs1, exp_rd(rs1_addr, 1'b0));
    chk({tag, "_n_rs2"}, idx, n_rs2, exp_rd(rs2_addr, 1'b0));
    chk({tag, "_n_haz"}, idx, {31'd0, n_haz}, {31'd0, exp_haz(1'b0)});
    chk({tag, "_n_cnt"}, idx, {26'd0, n_cnt}, exp_cnt());
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 5'd0,  32'h12345678, 5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd5, 5'd7, 1'b0, 5'd0, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b0, 6'd0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd7, 1'b1, 5'd3, 32'h0, 32'hA5A5A5A5, 1'b0, 6'd0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 6'd1};
    vecs[6]  = '{1'b1, 5'd3,  32'h11111111, 5'd3, 5'd0, 1'b0, 5'd0, 32'h11111111, 32'h0, 1'b0, 6'd1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 32'h11111111, 32'h0, 1'b0, 6'd0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd0, 1'b1, 5'd4, 32'h0, 32'h0, 1'b0, 6'd0};
    vecs[9]  = '{1'b1, 5'd4,  32'h44444444, 5'd0, 5'd0, 1'b1, 5'd4, 32'h0, 32'h0, 1'b0, 6'd1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 32'h44444444, 1'b1, 6'd1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 6'd1};
    vecs[12] = '{1'b1, 5'd9,  32'h99999999, 5'd9, 5'd0, 1'b1, 5'd6, 32'h99999999, 32'h0, 1'b0, 6'd2};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        5'd6, 5'd9, 1'b0, 5'd0, 32'h0, 32'h99999999, 1'b1, 6'd2};
    vecs[14] = '{1'b1, 5'd10, 32'hAAAA0000, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 6'd2};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 6'd2};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 6'd2};

    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b0, 5'd0);
    #2;
    chk("rst_rs1", 0, b_rs1, 32'd0);
    chk("rst_rs2", 0, b_rs2, 32'd0);
    chk("rst_haz", 0, {31'd0, b_haz}, 32'd0);
    chk("rst_cnt", 0, {26'd0, b_cnt}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed table against hand-derived expectations (bypass DUT) and the model (no bypass).
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2, vecs[i].ps, vecs[i].pa);
      #2;
      chk("tab_rs1", i, b_rs1, vecs[i].e1);
      chk("tab_rs2", i, b_rs2, vecs[i].e2);
      chk("tab_haz", i, {31'd0, b_haz}, {31'd0, vecs[i].eh});
      chk("tab_cnt", i, {26'd0, b_cnt}, {26'd0, vecs[i].ec});
      check_model("tab", i, 1'b0);
      tick();
    end

    // Fill the scoreboard: count must stop at 31 and ignore repeats and x0.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'(i));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b1, 5'd10);
    #2;
    chk("sat_full", 0, {26'd0, b_cnt}, 32'd31);
    chk("sat_haz", 0, {31'd0, b_haz}, 32'd1);
    tick();
    chk("sat_rep", 0, {26'd0, b_cnt}, 32'd31);
    chk("sat_rep_n", 0, {26'd0, n_cnt}, 32'd31);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
    tick();
    chk("sat_x0", 0, {26'd0, b_cnt}, 32'd31);
    drive(1'b1, 5'd10, 32'h0000BEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    chk("sat_clr", 0, {26'd0, b_cnt}, 32'd30);
    check_model("sat", 0, 1'b1);

    // Random traffic, mostly on a few registers so collisions happen often.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, int'(hi))), $urandom(),
            5'($urandom_range(0, int'(hi))), 5'($urandom_range(0, int'(hi))),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, int'(hi))));
      #2;
      check_model("rnd", i, 1'b1);
      tick();
    end

    // Asynchronous reset mid-cycle with a pending register being read.
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd2);
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd2, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd3, 1'b0, 5'd0);
    #2;
    chk("pre_rst_haz", 0, {31'd0, b_haz}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rs1", 0, b_rs1, 32'd0);
    chk("mid_rst_rs2", 0, b_rs2, 32'd0);
    chk("mid_rst_haz", 0, {31'd0, b_haz}, 32'd0);
    chk("mid_rst_cnt", 0, {26'd0, b_cnt}, 32'd0);
    chk("mid_rst_ncnt", 0, {26'd0, n_cnt}, 32'd0);
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check_model("post_rst", 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
